// File: rtl/sync_pkg.sv
// Shared helpers for the multi-channel synchronizer/filter: counter sizing,
// elaboration-time parameter validation and the per-channel result bundle.
package sync_pkg;

    // Filter counter width; at least one bit even when FILT_CYCLES is 1 or 2.
    function automatic int cnt_w(input int filt_cycles);
        int w;
        w = $clog2(filt_cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 1);
    endfunction

    function automatic bit stages_ok(input int stages);
        return (stages >= 2);
    endfunction

    function automatic bit filt_ok(input int filt_cycles);
        return (filt_cycles >= 1);
    endfunction

    function automatic bit params_ok(input int width, input int stages, input int filt_cycles);
        return width_ok(width) && stages_ok(stages) && filt_ok(filt_cycles);
    endfunction

    typedef struct packed {
        logic sync;
        logic filt;
        logic rise;
        logic fall;
    } chan_out_t;

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: STAGES-deep synchronizer chain, stability filter and
// registered rise/fall pulses that coincide with the filtered level change.
module sync_filter_bit
    import sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      async_in,
    output chan_out_t chan
);

    localparam int             CW       = cnt_w(FILT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage;

    logic          sync_lvl;
    logic          filt_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic          mismatch;
    logic          accept;

    // Plain flop chain: nothing may sit between stages or feed back into stage[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= {STAGES{RESET_VAL}};
        end else begin
            stage <= {stage[STAGES-2:0], async_in};
        end
    end

    assign sync_lvl = stage[STAGES-1];
    assign mismatch = sync_lvl ^ filt_q;
    assign accept   = mismatch && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= RESET_VAL;
        end else if (!mismatch) begin
            cnt_q  <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            filt_q <= sync_lvl;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // Pulses share the accept edge so they line up with the new filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= accept &  sync_lvl;
            fall_q <= accept & ~sync_lvl;
        end
    end

    always_comb begin
        chan      = '0;
        chan.sync = sync_lvl;
        chan.filt = filt_q;
        chan.rise = rise_q;
        chan.fall = fall_q;
    end

endmodule

// File: rtl/sync_filter_array.sv
// WIDTH independent synchronizer/glitch-filter/edge-detect channels for
// asynchronous control lines entering the clk domain.
module sync_filter_array
    import sync_pkg::*;
#(
    parameter int   WIDTH       = 4,
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    if (!params_ok(WIDTH, STAGES, FILT_CYCLES)) begin : g_bad_params
        $fatal(1, "sync_filter_array: need WIDTH>=1, STAGES>=2, FILT_CYCLES>=1");
    end

    chan_out_t chan [WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_bit #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_VAL   (RESET_VAL)
        ) u_bit (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (async_in[i]),
            .chan     (chan[i])
        );

        assign sync_out[i]   = chan[i].sync;
        assign filt_out[i]   = chan[i].filt;
        assign rise_pulse[i] = chan[i].rise;
        assign fall_pulse[i] = chan[i].fall;
    end

endmodule

// File: tb/tb_sync_filter_array.sv
// Directed + random stimulus for sync_filter_array (4 ch, 2 stages, 3-cycle
// filter) with a windowed reference model feeding an expected-output queue.
module tb_sync_filter_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic [3:0] filt_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] f;
        logic [3:0] r;
        logic [3:0] fl;
    } exp_t;

    exp_t exp_q[$];

    // Model: two-deep sample history, plus last three synchronized samples;
    // filt flips on a channel when all three differ from the current filt.
    logic [3:0] m_st0, m_st1, m_h0, m_h1, m_h2, m_filt;

    sync_filter_array #(
        .WIDTH       (4),
        .STAGES      (2),
        .FILT_CYCLES (3),
        .RESET_VAL   (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (async_in),
        .sync_out   (sync_out),
        .filt_out   (filt_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st0 = 4'h0; m_st1 = 4'h0;
        m_h0 = 4'h0; m_h1 = 4'h0; m_h2 = 4'h0;
        m_filt = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync"}, sync_out, 4'h0);
        check({tag, "_filt"}, filt_out, 4'h0);
        check({tag, "_rise"}, rise_pulse, 4'h0);
        check({tag, "_fall"}, fall_pulse, 4'h0);
    endtask

    // Drive one input value for one edge, push the model's prediction,
    // then pop and compare once the edge has been taken.
    task automatic step(input logic [3:0] a);
        exp_t       e;
        logic [3:0] acc;
        @(negedge clk);
        async_in = a;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = m_st1;
        acc  = (m_h0 ^ m_filt) & (m_h1 ^ m_filt) & (m_h2 ^ m_filt);
        m_filt = m_filt ^ acc;
        m_st1 = m_st0;
        m_st0 = a;
        e.s  = m_st1;
        e.f  = m_filt;
        e.r  = acc & m_h0;
        e.fl = acc & ~m_h0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sync", sync_out, e.s);
        check("filt", filt_out, e.f);
        check("rise", rise_pulse, e.r);
        check("fall", fall_pulse, e.fl);
    endtask

    initial begin
        int rise0_cnt;
        logic [3:0] v;
        int hold;

        // Reset held with all inputs high: nothing may leak through.
        rst_n    = 1'b0;
        async_in = 4'hF;
        model_reset();
        #1;
        check_all_zero("rst_init");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_all_zero("rst_hold");
        end

        // Step: ch0 rises, visible on sync after E1, filt/rise after E4.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(4'b0001);
            if (i == 1) check("step_sync_e1", sync_out, 4'b0001);
            if (i == 3) check("step_filt_e3", filt_out, 4'b0000);
            if (i == 4) check("step_rise_e4", rise_pulse, 4'b0001);
            if (i == 5) check("step_rise_e5", rise_pulse, 4'b0000);
        end

        // Glitch: two-cycle high on ch1 is rejected.
        step(4'b0011);
        step(4'b0011);
        for (int i = 0; i < 6; i++) begin
            step(4'b0001);
            check("glitch_filt1", filt_out & 4'b0010, 4'b0000);
            check("glitch_rise1", rise_pulse & 4'b0010, 4'b0000);
        end

        // Fall on ch0.
        for (int i = 0; i < 7; i++) begin
            step(4'b0000);
            if (i == 4) check("fall_pulse_e4", fall_pulse, 4'b0001);
            if (i == 4) check("fall_filt_e4", filt_out, 4'b0000);
        end

        // Settle ch3 high, then rise ch2 and fall ch3 together.
        for (int i = 0; i < 7; i++) step(4'b1000);
        for (int i = 0; i < 7; i++) begin
            step(4'b0100);
            if (i == 4) check("simul_rise", rise_pulse, 4'b0100);
            if (i == 4) check("simul_fall", fall_pulse, 4'b1000);
        end

        // Reset mid-count: ch0 rising with two mismatch cycles counted.
        for (int i = 0; i < 4; i++) step(4'b0101);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_mid_hold");
        rst_n = 1'b1;
        rise0_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(4'b0101);
            if (rise_pulse[0]) rise0_cnt++;
            if (i == 3) check("rst_rel_e3", rise_pulse, 4'b0000);
            if (i == 4) check("rst_rel_e4", rise_pulse, 4'b0101);
        end
        check("rst_rel_once", 4'(rise0_cnt), 4'd1);

        // Random levels with random hold times, glitches included.
        for (int n = 0; n < 30; n++) begin
            v    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 5);
            for (int k = 0; k < hold; k++) step(v);
        end
        for (int i = 0; i < 6; i++) step(v);

        check("queue_empty", 4'(exp_q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_filter_array.md
# sync_filter_array

Parametrised multi-channel synchronizer with per-channel glitch filter and edge detection. Each bit of an asynchronous input bus passes through a STAGES-deep flop chain into the clk domain. A FILT_CYCLES-long stability filter follows the chain. Single-cycle rise/fall pulses mark each accepted transition. It sits at the boundary between off-chip/asynchronous control lines (buttons, status pins, other-domain levels) and synchronous logic, and supersedes the fixed single-bit two-flop synchronizer for new designs.

## Interface
- WIDTH, 4: number of independent channels; ≥1.
- STAGES, 2: synchronizer flops per channel; ≥2.
- FILT_CYCLES, 3: consecutive cycles a new synchronized level must hold before acceptance; ≥1.
- RESET_VAL, 1'b0: reset level of every synchronizer stage and filtered output, all channels.

- clk  input  1  single clock for all logic.
- rst_n  input  1  reset, asynchronous, active-low.
- async_in  input  WIDTH  asynchronous level inputs, no timing relationship to clk.
- sync_out  output  WIDTH  raw synchronizer output (last stage), unfiltered.
- filt_out  output  WIDTH  filtered, debounced level.
- rise_pulse  output  WIDTH  one-cycle high when filt_out[i] goes 0→1.
- fall_pulse  output  WIDTH  one-cycle high when filt_out[i] goes 1→0.

## Operation
- Reset (rst_n=0, immediate, independent of clk):
  - all stages and filt_out = RESET_VAL;
  - counters = 0;
  - rise_pulse = fall_pulse = 0.
- Synchronizer: stage[0] ← async_in[i] each edge; stage[k] ← stage[k-1]; sync_out[i] = stage[STAGES-1]. No logic between stages.
- Filter, per channel, counter cnt of width $clog2(FILT_CYCLES) (min 1 bit):
  - sync_out==filt_out: cnt ← 0.
  - mismatch and cnt < FILT_CYCLES-1: cnt ← cnt+1.
  - mismatch and cnt == FILT_CYCLES-1: filt_out ← sync_out, cnt ← 0.
  - A mismatch run shorter than FILT_CYCLES cycles is discarded; any return to equality restarts the count.
- Edge pulses are registered on the same edge that updates filt_out:
  - rise_pulse[i] = 1 in exactly the first cycle filt_out[i]=1.
  - fall_pulse[i] = 1 in exactly the first cycle filt_out[i]=0.
  - Never both high on one channel.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- After reset release, if async_in differs from RESET_VAL, that difference is a genuine transition and yields a normal pulse after full latency.
- Reset mid-count aborts the count; no pulse is produced for the aborted transition.

## Timing
- Let E0 be the first rising edge at which a new async_in level is sampled into stage[0].
- sync_out updates after edge E0+STAGES-1.
- filt_out and the corresponding pulse update after edge E0+STAGES-1+FILT_CYCLES.
- Total latency = STAGES+FILT_CYCLES-1 edges after E0. Example (STAGES=2, FILT_CYCLES=3): valid after E4.
- A pulse is exactly one clk cycle wide.
- Minimum accepted input level duration is FILT_CYCLES cycles at sync_out.
- Metastability resolution is STAGES-1 cycles; the design relies on the chain only, with no feedback into stage[0].

## Structure
- Package sync_pkg holds:
  - the counter width function cnt_w(FILT_CYCLES);
  - elaboration-time parameter checks (STAGES≥2, FILT_CYCLES≥1, WIDTH≥1), triggering $fatal on violation.
- Sub-module sync_filter_bit implements one channel (stage chain, counter, filt, pulses). The top instantiates it WIDTH times via generate.
- Synchronizer stage flops carry the team's async-register attribute.

## Test plan
Parameters WIDTH=4, STAGES=2, FILT_CYCLES=3, RESET_VAL=0.
- Reset: rst_n=0, async_in=4'hF for 5 cycles → sync_out=0, filt_out=0, rise/fall=0 throughout; outputs clear immediately on rst_n fall, without waiting for a clk edge.
- Step: release reset, async_in 0→4'b0001 before E0 → sync_out=4'b0001 after E1, filt_out=4'b0001 after E4, rise_pulse=4'b0001 for the single cycle after E4, then 0.
- Glitch: async_in[1] high for 2 cycles → sync_out[1] high 2 cycles, filt_out[1] stays 0, no pulse on channel 1.
- Fall: async_in[0] 1→0 sampled at E0 → filt_out[0]=0 and fall_pulse=4'b0001 for one cycle after E4.
- Simultaneous: async_in[2] 0→1 and async_in[3] 1→0 (ch3 pre-settled high) in the same cycle → rise_pulse[2] and fall_pulse[3] in the same cycle; other channels quiet.
- Reset mid-count: ch0 rising with cnt=2 pending, assert rst_n=0 → filt_out=0 and pulses=0 immediately. After release with async_in[0] held 1, rise_pulse[0] fires only after full latency (E4 from first sample), exactly once.
